alu_operand_stage: RTL

ID/EX pipeline register and operand-forwarding front end for the execute-stage ALU. Captures decoded operands and control on each cycle, resolves RAW hazards by forwarding from the MEM and WB stages, applies the immediate select, and drives the ALU's `num1`, `num2` and `alu_control` inputs directly. Also screens out ALU control codes the ALU does not implement.

---
 rtl/alu_operand_stage.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding that drives the execute-stage ALU.
// Optional feature: define ALU_FWD_EN to enable forward muxes and hold-time forward capture.
module alu_operand_stage #(
  parameter bit ZERO_FWD = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_alusrc,
  input  logic [2:0]  id_alu_control,
  input  logic        id_regwrite,
  input  logic [4:0]  id_writereg,
  input  logic        mem_regwrite,
  input  logic [4:0]  mem_writereg,
  input  logic [31:0] mem_result,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_writereg,
  input  logic [31:0] wb_result,
  input  logic        ex_hold,
  input  logic        ex_flush,
  output logic [31:0] num1,
  output logic [31:0] num2,
  output logic [2:0]  alu_control,
  output logic        ex_valid,
  output logic        ex_regwrite,
  output logic [4:0]  ex_writereg,
  output logic [31:0] ex_store_data,
  output logic        ex_illegal
);

  typedef struct packed {
    logic        valid;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        alusrc;
    logic [2:0]  alu_control;
    logic        regwrite;
    logic [4:0]  writereg;
    logic        illegal;
  } ex_reg_t;

  ex_reg_t ex_q;
  ex_reg_t ex_d;
  ex_reg_t id_fields;

  logic [31:0] rs_fwd;
  logic [31:0] rt_fwd;

  function automatic logic code_legal(input logic [2:0] code);
    case (code)
      3'b000, 3'b001, 3'b010, 3'b110, 3'b111: code_legal = 1'b1;
      default:                                code_legal = 1'b0;
    endcase
  endfunction

  // Decode-side image of the EX register; an empty slot loads as a bubble.
  always_comb begin
    // NOTE: every field gets a default first so no path leaves a latch behind.
    id_fields = '0;
    if (id_valid) begin
      id_fields.valid       = 1'b1;
      id_fields.rs_data     = id_rs_data;
      id_fields.rt_data     = id_rt_data;
      id_fields.imm         = id_imm;
      id_fields.rs          = id_rs;
      id_fields.rt          = id_rt;
      id_fields.alusrc      = id_alusrc;
      id_fields.alu_control = id_alu_control;
      id_fields.regwrite    = id_regwrite;
      id_fields.writereg    = id_writereg;
      if (!code_legal(id_alu_control)) begin
        id_fields.alu_control = 3'b000;
        id_fields.illegal     = 1'b1;
        id_fields.regwrite    = 1'b0;
      end
    end
  end

`ifdef ALU_FWD_EN
  function automatic logic fwd_hit(input logic       we,
                                   input logic [4:0] dst,
                                   input logic [4:0] src);
    fwd_hit = we && (dst == src) && ((src != 5'd0) || ZERO_FWD);
  endfunction

  // MEM is younger than WB, so it wins when both write the same register.
  always_comb begin
    rs_fwd = ex_q.rs_data;
    if (fwd_hit(mem_regwrite, mem_writereg, ex_q.rs))
      rs_fwd = mem_result;
    else if (fwd_hit(wb_regwrite, wb_writereg, ex_q.rs))
      rs_fwd = wb_result;

    rt_fwd = ex_q.rt_data;
    if (fwd_hit(mem_regwrite, mem_writereg, ex_q.rt))
      rt_fwd = mem_result;
    else if (fwd_hit(wb_regwrite, wb_writereg, ex_q.rt))
      rt_fwd = wb_result;
  end
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{mem_regwrite, mem_writereg, mem_result,
                               wb_regwrite, wb_writereg, wb_result};
  assign rs_fwd = ex_q.rs_data;
  assign rt_fwd = ex_q.rt_data;
`endif

  always_comb begin
    ex_d = ex_q;
    if (ex_flush) begin
      ex_d = '0;
    end else if (ex_hold) begin
`ifdef ALU_FWD_EN
      // Absorb forwarded values while stalled; WB may retire before the hold lifts.
      ex_d.rs_data = rs_fwd;
      ex_d.rt_data = rt_fwd;
`endif
    end else begin
      ex_d = id_fields;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign num1          = rs_fwd;
  assign ex_store_data = rt_fwd;
  assign num2          = ex_q.alusrc ? ex_q.imm : rt_fwd;
  assign alu_control   = ex_q.alu_control;
  assign ex_valid      = ex_q.valid;
  assign ex_regwrite   = ex_q.valid & ex_q.regwrite;
  assign ex_illegal    = ex_q.valid & ex_q.illegal;
  assign ex_writereg   = ex_q.writereg;

endmodule
